// File: rtl/rf_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// rf_sequencer_pkg : op encodings, FSM states and size defaults | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rf_sequencer_pkg;

  localparam int NREG_DEFAULT  = 8;
  localparam int WIDTH_DEFAULT = 8;
  localparam int IDX_W         = 3;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_MOV = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    IDLE  = 3'd1,
    READ  = 3'd2,
    EXEC  = 3'd3,
    WRITE = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rf_sequencer_if.sv
// ---------------------------------------------------------------------------
// rf_sequencer_if : request/response handshake bundle | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface rf_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [2:0]       req_ra;
  logic [2:0]       req_rb;
  logic [2:0]       req_rw;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;

  modport master (
    output req_valid, req_op, req_ra, req_rb, req_rw,
    input  req_ready, rsp_valid, rsp_data, rsp_zero
  );

  modport slave (
    input  req_valid, req_op, req_ra, req_rb, req_rw,
    output req_ready, rsp_valid, rsp_data, rsp_zero
  );
endinterface

`default_nettype wire

// File: rtl/rf_seq_alu.sv
// ---------------------------------------------------------------------------
// rf_seq_alu : combinational op -> result mapping with zero flag | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rf_seq_alu
  import rf_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  // All arithmetic wraps at WIDTH bits; no carry/borrow is exported.
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_MOV:  result = a;
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

`default_nettype wire

// File: rtl/rf_sequencer.sv
// ---------------------------------------------------------------------------
// rf_sequencer : register-file clear + read/exec/write sequencer | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rf_sequencer
  import rf_sequencer_pkg::*;
#(
  parameter int NREG  = NREG_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  rf_sequencer_if.slave       bus,
  output logic                init_done,
  output logic                RFWrite,
  output logic [IDX_W-1:0]    regA,
  output logic [IDX_W-1:0]    regB,
  output logic [IDX_W-1:0]    regw,
  output logic [WIDTH-1:0]    dataW,
  input  logic [WIDTH-1:0]    dataA,
  input  logic [WIDTH-1:0]    dataB
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREG - 1);

  state_t             state;
  state_t             state_nx;
  logic [IDX_W-1:0]   cnt;
  op_t                op_q;
  logic [IDX_W-1:0]   ra_q;
  logic [IDX_W-1:0]   rb_q;
  logic [IDX_W-1:0]   rw_q;
  logic [WIDTH-1:0]   opa_q;
  logic [WIDTH-1:0]   opb_q;
  logic [WIDTH-1:0]   rsp_data_q;
  logic               rsp_zero_q;
  logic [IDX_W-1:0]   regw_q;
  logic [WIDTH-1:0]   dataW_q;
  logic               accept;
  logic               ready;
  logic               rsp_pulse;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_zero;

  rf_seq_alu #(.WIDTH(WIDTH)) u_alu (
    .op     (op_q),
    .a      (opa_q),
    .b      (opb_q),
    .result (alu_res),
    .zero   (alu_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= INIT;
      cnt        <= '0;
      init_done  <= 1'b0;
      op_q       <= OP_ADD;
      ra_q       <= '0;
      rb_q       <= '0;
      rw_q       <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
      regw_q     <= '0;
      dataW_q    <= '0;
    end else begin
      state   <= state_nx;
      regw_q  <= regw;
      dataW_q <= dataW;
      if (state == INIT) begin
        cnt <= cnt + 1'b1;
        if (cnt == LAST_IDX) begin
          init_done <= 1'b1;
        end
      end
      if (accept) begin
        op_q <= op_t'(bus.req_op);
        ra_q <= bus.req_ra;
        rb_q <= bus.req_rb;
        rw_q <= bus.req_rw;
      end
      if (state == READ) begin
        opa_q <= dataA;
        opb_q <= dataB;
      end
      // Result is frozen here so rsp_data/dataW hold it through WRITE and beyond.
      if (state == EXEC) begin
        rsp_data_q <= alu_res;
        rsp_zero_q <= alu_zero;
      end
    end
  end

  // Strobes are masked by reset so an in-flight WRITE never commits on the reset edge.
  always_comb begin
    state_nx  = state;
    RFWrite   = 1'b0;
    regw      = regw_q;
    dataW     = dataW_q;
    ready     = 1'b0;
    rsp_pulse = 1'b0;
    accept    = 1'b0;
    case (state)
      INIT: begin
        RFWrite = !reset;
        regw    = cnt;
        dataW   = '0;
        if (cnt == LAST_IDX) begin
          state_nx = IDLE;
        end
      end
      IDLE: begin
        ready  = !reset;
        accept = bus.req_valid && !reset;
        if (accept) begin
          state_nx = READ;
        end
      end
      READ: begin
        state_nx = EXEC;
      end
      EXEC: begin
        state_nx = WRITE;
      end
      WRITE: begin
        RFWrite   = !reset;
        regw      = rw_q;
        dataW     = rsp_data_q;
        rsp_pulse = !reset;
        state_nx  = IDLE;
      end
      default: begin
        state_nx = INIT;
      end
    endcase
  end

  assign regA          = ra_q;
  assign regB          = rb_q;
  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_pulse;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rf_sequencer : directed table-driven bench with 8x8 register-file model | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rf_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       init_done;
  logic       RFWrite;
  logic [2:0] regA, regB, regw;
  logic [7:0] dataW, dataA, dataB;

  logic       pre_we   = 1'b0;
  logic [2:0] pre_addr = '0;
  logic [7:0] pre_data = '0;
  logic [7:0] rf [8];

  int n_checks = 0;
  int n_fail   = 0;
  int n_wr     = 0;
  int n_rsp    = 0;
  int cyc      = 0;

  rf_sequencer_if #(.WIDTH(8)) bus ();

  rf_sequencer #(.NREG(8), .WIDTH(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .init_done (init_done),
    .RFWrite   (RFWrite),
    .regA      (regA),
    .regB      (regB),
    .regw      (regw),
    .dataW     (dataW),
    .dataA     (dataA),
    .dataB     (dataB)
  );

  always #5 clock = ~clock;

  // Register file: asynchronous read, write on the rising edge.
  assign dataA = rf[regA];
  assign dataB = rf[regB];
  always @(posedge clock) begin
    if (RFWrite) rf[regw] <= dataW;
    else if (pre_we) rf[pre_addr] <= pre_data;
  end

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (RFWrite) n_wr <= n_wr + 1;
    if (bus.rsp_valid) n_rsp <= n_rsp + 1;
  end

  typedef struct {
    logic       pre;
    logic [7:0] p1;
    logic [7:0] p2;
    logic [1:0] op;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [2:0] rw;
    logic [7:0] exp;
    logic       zero;
  } vec_t;

  vec_t vt [6];
  vec_t bt [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [2:0] a, input logic [7:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge clock);
    pre_we   = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    bus.req_op = v.op;
    bus.req_ra = v.ra;
    bus.req_rb = v.rb;
    bus.req_rw = v.rw;
  endtask

  task automatic run_req(input vec_t v);
    drive(v);
    bus.req_valid = 1'b1;
    #1;
    chk("req_ready_idle", bus.req_ready, 1);
    @(negedge clock);
    bus.req_valid = 1'b0;
    chk("read_regA", regA, v.ra);
    chk("read_regB", regB, v.rb);
    chk("read_nowrite", RFWrite, 0);
    chk("read_notready", bus.req_ready, 0);
    @(negedge clock);
    chk("exec_nowrite", RFWrite, 0);
    chk("exec_norsp", bus.rsp_valid, 0);
    @(negedge clock);
    chk("write_rsp_valid", bus.rsp_valid, 1);
    chk("write_rfwrite", RFWrite, 1);
    chk("write_regw", regw, v.rw);
    chk("write_dataW", dataW, v.exp);
    chk("write_rsp_data", bus.rsp_data, v.exp);
    chk("write_rsp_zero", bus.rsp_zero, v.zero);
    @(negedge clock);
    chk("after_rsp_low", bus.rsp_valid, 0);
    chk("after_rf_value", rf[v.rw], v.exp);
    chk("after_rsp_hold", bus.rsp_data, v.exp);
  endtask

  initial begin
    int w0, r0, last, t;

    //         pre  p1     p2     op  ra  rb  rw  exp    zero
    vt[0] = '{1'b1, 8'h05, 8'h03, 2'd0, 3'd1, 3'd2, 3'd3, 8'h08, 1'b0};
    vt[1] = '{1'b1, 8'h03, 8'h05, 2'd1, 3'd1, 3'd2, 3'd1, 8'hFE, 1'b0};
    vt[2] = '{1'b0, 8'h00, 8'h00, 2'd1, 3'd1, 3'd1, 3'd4, 8'h00, 1'b1};
    vt[3] = '{1'b0, 8'h00, 8'h00, 2'd2, 3'd1, 3'd3, 3'd5, 8'h08, 1'b0};
    vt[4] = '{1'b0, 8'h00, 8'h00, 2'd3, 3'd1, 3'd0, 3'd6, 8'hFE, 1'b0};
    vt[5] = '{1'b0, 8'h00, 8'h00, 2'd0, 3'd1, 3'd1, 3'd7, 8'hFC, 1'b0};
    // State entering burst: r1=FE r2=05 r3=08 r4=00 r5=08 r6=FE r7=FC
    bt[0] = '{1'b0, 8'h00, 8'h00, 2'd0, 3'd2, 3'd3, 3'd0, 8'h0D, 1'b0};
    bt[1] = '{1'b0, 8'h00, 8'h00, 2'd1, 3'd0, 3'd2, 3'd2, 8'h08, 1'b0};
    bt[2] = '{1'b0, 8'h00, 8'h00, 2'd2, 3'd1, 3'd7, 3'd3, 8'hFC, 1'b0};
    bt[3] = '{1'b0, 8'h00, 8'h00, 2'd3, 3'd3, 3'd0, 3'd4, 8'hFC, 1'b0};

    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_ra    = '0;
    bus.req_rb    = '0;
    bus.req_rw    = '0;

    // Reset with the register file seeded with non-zero junk.
    repeat (2) @(negedge clock);
    for (int i = 0; i < 8; i++) preload(3'(i), 8'hA0 + 8'(i));
    chk("rst_rfwrite", RFWrite, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_zero", bus.rsp_zero, 0);

    reset = 1'b0;
    #1;
    w0 = n_wr;
    for (int i = 0; i < 8; i++) begin
      chk("init_rfwrite", RFWrite, 1);
      chk("init_regw", regw, i);
      chk("init_dataW", dataW, 0);
      chk("init_not_done", init_done, 0);
      @(negedge clock);
    end
    chk("init_write_count", n_wr - w0, 8);
    chk("init_done_9th", init_done, 1);
    chk("ready_9th", bus.req_ready, 1);
    chk("idle_nowrite", RFWrite, 0);
    for (int i = 0; i < 8; i++) chk("init_cleared", rf[i], 0);

    // Table-driven single requests.
    for (int k = 0; k < 6; k++) begin
      if (vt[k].pre) begin
        preload(3'd1, vt[k].p1);
        preload(3'd2, vt[k].p2);
      end
      run_req(vt[k]);
    end

    // req_valid held high: one acceptance every 4 cycles.
    w0 = n_wr;
    r0 = n_rsp;
    last = 0;
    drive(bt[0]);
    bus.req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      t = 0;
      while (!bus.req_ready && t < 10) begin
        @(negedge clock);
        t++;
      end
      chk("burst_ready_timeout", (t < 10), 1);
      if (k > 0) chk("burst_interval", cyc - last, 4);
      last = cyc;
      @(negedge clock);
      if (k < 3) drive(bt[k+1]);
      repeat (2) @(negedge clock);
      if (k == 3) bus.req_valid = 1'b0;
      chk("burst_rsp_valid", bus.rsp_valid, 1);
      chk("burst_rsp_data", bus.rsp_data, bt[k].exp);
      chk("burst_regw", regw, bt[k].rw);
      @(negedge clock);
    end
    repeat (4) @(negedge clock);
    chk("burst_write_count", n_wr - w0, 4);
    chk("burst_rsp_count", n_rsp - r0, 4);
    for (int k = 0; k < 4; k++) chk("burst_rf", rf[bt[k].rw], bt[k].exp);

    // Reset in EXEC of an AND targeting r5.
    preload(3'd5, 8'h77);
    bus.req_op = 2'd2;
    bus.req_ra = 3'd1;
    bus.req_rb = 3'd3;
    bus.req_rw = 3'd5;
    bus.req_valid = 1'b1;
    @(negedge clock);
    bus.req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    w0 = n_wr;
    r0 = n_rsp;
    #1;
    chk("abort_rfwrite_in_rst", RFWrite, 0);
    chk("abort_rsp_in_rst", bus.rsp_valid, 0);
    @(negedge clock);
    chk("abort_r5_kept", rf[5], 8'h77);
    chk("abort_rfwrite", RFWrite, 0);
    chk("abort_rsp_data_clr", bus.rsp_data, 0);
    @(negedge clock);
    chk("abort_no_write", n_wr - w0, 0);
    chk("abort_no_rsp", n_rsp - r0, 0);

    // Reset mid-INIT restarts the clear sequence at index 0.
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("init_restart_regw", regw, 0);
    chk("init_restart_done", init_done, 0);
    w0 = n_wr;
    repeat (8) @(negedge clock);
    chk("reinit_write_count", n_wr - w0, 8);
    chk("reinit_done", init_done, 1);
    chk("reinit_r5_cleared", rf[5], 0);
    for (int i = 0; i < 8; i++) chk("reinit_cleared", rf[i], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/rf_sequencer.md
RF_SEQUENCER -- requirements
Module: rf_sequencer

Interface
REQ-001 Parameters: NREG, default 8, number of registers addressed; WIDTH, default 8, data width.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clock  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 req_op  in  2  operation: 0=ADD, 1=SUB, 2=AND, 3=MOV (A passthrough).
REQ-008 req_ra, req_rb, req_rw  in  3 each  source A, source B and destination register indices.
REQ-009 rsp_valid  out  1  one-cycle result pulse.
REQ-010 rsp_data  out  WIDTH  result written back.
REQ-011 rsp_zero  out  1  rsp_data == 0.
REQ-012 init_done  out  1  register-clear sequence complete.
REQ-013 RFWrite  out  1  register-file write enable.
REQ-014 regA, regB, regw  out  3 each  register-file read/write indices.
REQ-015 dataW  out  WIDTH  register-file write data.
REQ-016 dataA, dataB  in  WIDTH  register-file asynchronous read data.

Function
REQ-017 The FSM SHALL have the states INIT, IDLE, READ, EXEC and WRITE.
REQ-018 INIT: a 3-bit counter SHALL step 0..7, asserting RFWrite=1, regw=counter and dataW=0 for one cycle each; after index 7 the FSM SHALL go to IDLE and init_done SHALL rise and stay 1 until reset.
REQ-019 IDLE: req_ready=1; a request SHALL be accepted only when req_valid && req_ready; req_op, req_ra, req_rb and req_rw SHALL be latched on acceptance; the next state SHALL be READ.
REQ-020 Outside IDLE, req_ready SHALL be 0 and req_valid SHALL be ignored; no request is queued.
REQ-021 READ: regA and regB SHALL carry the latched indices, and dataA/dataB SHALL be captured into operand registers at the end of the cycle; the next state SHALL be EXEC.
REQ-022 EXEC: the result SHALL be computed modulo 2^WIDTH (SUB = A - B wrapped, no carry or borrow output); the next state SHALL be WRITE.
REQ-023 WRITE: RFWrite=1, regw=latched req_rw and dataW=result for exactly one cycle; rsp_valid=1 in the same cycle with rsp_data=result; the next state SHALL be IDLE.
REQ-024 Latency: a request accepted at edge T SHALL produce a write/rsp_valid cycle beginning at edge T+3; throughput SHALL be one request per 4 cycles.
REQ-025 req_rw equal to req_ra or req_rb SHALL be legal; operands are captured in READ, before the WRITE.
REQ-026 RFWrite SHALL be 0 in IDLE, READ and EXEC.
REQ-027 regA, regB, regw and dataW SHALL hold their last values when unused; rsp_data SHALL hold its value between pulses.

Reset
REQ-028 On reset the block SHALL enter INIT with counter=0, init_done=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_zero=0, RFWrite=0 in the reset cycle, and operand registers = 0.
REQ-029 Reset asserted during READ, EXEC or WRITE SHALL abort the operation: no write after the reset edge and no rsp_valid, followed by a complete INIT sequence.
REQ-030 Reset asserted during INIT SHALL restart the counter at 0.

Structure
REQ-031 A shared package SHALL hold the op encodings (ADD/SUB/AND/MOV), the FSM state enumeration, and the NREG/WIDTH defaults.
REQ-032 One sub-module rf_seq_alu SHALL implement the combinational op→result mapping plus the zero flag; the FSM and counters SHALL stay in rf_sequencer.

Verification
REQ-033 The bench SHALL pair the DUT with a behavioural 8x8 register file model with asynchronous read and write on the clock edge.
REQ-034 Release reset -> exactly 8 write cycles to r0..r7 with data 0, then init_done=1 and req_ready=1 on the 9th cycle.
REQ-035 Preload r1=0x05, r2=0x03; ADD ra=1 rb=2 rw=3 -> rsp_valid 3 cycles after acceptance, rsp_data=0x08, r3=0x08, rsp_zero=0.
REQ-036 r1=0x03, r2=0x05; SUB rw=1 -> rsp_data=0xFE (wrap), and r1 becomes 0xFE. Then SUB ra=1 rb=1 rw=4 -> rsp_data=0x00, rsp_zero=1.
REQ-037 Hold req_valid high continuously with differing requests -> acceptance exactly every 4 cycles, no lost or duplicated writes, and each result matches the model.
REQ-038 Assert reset in EXEC of an AND to r5 (prior value 0x77) -> no write of the AND result and no rsp_valid; INIT then clears r5 to 0x00.
